pxie_cmd_decoder: RTL and testbench
===================================

# pxie_cmd_decoder

Parametrised PXIe host-command decoder for the instrument FPGA. It sits directly behind the PXIe endpoint's receive stream in the I_PXIE_CLK domain and parses tagged 64-bit control words. It produces stretched reset/trigger/run pulses, holds trigger and C2H read configuration, and streams burst payloads into NUM_CH independent RAM write ports with a per-channel base address. It adds burst timeout, illegal-command detection and a sticky error flag.

## Interface
Reset is synchronous, active-low (I_Rst_n); single clock I_PXIE_CLK.
- DATA_W, 128, stream/payload width (≥64)
- NUM_CH, 4, number of RAM write channels (1..16)
- ADDR_W, 32, write address width
- ADDR_STEP, 2, address increment per payload word
- PULSE_LEN, 50, stretched pulse length in cycles (≥1)
- TIMEOUT_CYC, 1024, max idle cycles inside a burst
- I_PXIE_CLK  in  1  clock
- I_Rst_n  in  1  synchronous active-low reset
- I_PXIE_DATA  in  DATA_W  stream word; header fields in [63:0]
- I_PXIE_DATA_VLD  in  1  word qualifier
- O_Rst  out  1  reset pulse, PULSE_LEN cycles
- O_Trig  out  1  trigger pulse, PULSE_LEN cycles
- O_run  out  1  run pulse, PULSE_LEN cycles
- O_Trig_Num  out  32  trigger count
- O_Trig_Step  out  32  trigger step
- O_wr_en  out  NUM_CH  one-hot write strobe
- O_wr_addr  out  ADDR_W  write address (shared)
- O_wr_data  out  DATA_W  write data (shared)
- O_c2h_addr  out  16  C2H start address
- O_c2h_len  out  16  C2H length
- O_c2h_en  out  1  one-cycle C2H request
- O_busy  out  1  high in ST_WRITE
- O_err  out  1  sticky error

## Operation
- Tag = [63:48]; only VLD words in ST_HEAD are decoded; non-matching words ignored.
- Tag EB9C, [47:32]=0000: command opcode [15:0]: 0001 → start O_Rst stretch, clear O_err; 0002 → O_Trig; 1100 → O_run; 1010 → O_c2h_en one cycle; 1000+c → burst to channel c.
- Tag EB9C, [47:32]=0003 → O_Trig_Num ← [31:0]; 0004 → O_Trig_Step ← [31:0].
- Tag EB00+c (c<NUM_CH) → base[c] ← [ADDR_W-1:0] (of [31:0], zero-extended if ADDR_W>32), len[c] ← [47:32].
- Tag EBF0 → O_c2h_addr ← [15:0], O_c2h_len ← [31:16].
- Channel index c ≥ NUM_CH in either tag or opcode → O_err set, word ignored.
- FSM: ST_HEAD → ST_WRITE on burst opcode with len[c]≠0; len[c]=0 stays in ST_HEAD, no write. ST_WRITE → ST_HEAD after len[c] payload words or timeout.
- In ST_WRITE every VLD word is payload (never decoded): O_wr_en[c]=1, O_wr_data=word, O_wr_addr=base[c]+k·ADDR_STEP, k=0..len−1 (mod 2^ADDR_W wrap). base[c] not modified by the burst.
- Pulse stretch counters independent per output; re-issue while active restarts count to full PULSE_LEN. Pulses do not block parsing.
- Reset values: all outputs 0, base/len registers 0, state ST_HEAD, counters 0.

## Timing
- All outputs registered; header at cycle t → effect visible t+1.
- Pulse: high t+1 … t+PULSE_LEN.
- Payload word at t → O_wr_en/addr/data at t+1, one cycle. VLD gaps insert no strobes.
- Last payload at t → ST_HEAD at t+1; a header at t+1 is decoded (zero dead cycles).
- Burst opcode at t → first payload accepted at t+1.
- Timeout: TIMEOUT_CYC consecutive non-VLD cycles in ST_WRITE → ST_HEAD next cycle, O_err=1; already written words stand.
- Reset asserted mid-burst or mid-pulse: everything returns to reset values on the next edge.
- RST command and a new error in the same cycle: clear wins.

## Configuration
- PXIE_RX_TIMEOUT_EN defined: timeout counter present as above.
- Undefined: no counter; ST_WRITE waits indefinitely for payload; O_err set only by illegal channel.

## Structure
- Package pxie_rx_pkg: tag constants (EB9C, EB00, EBF0), sub-field codes (0003, 0004), opcodes (0001, 0002, 1000, 1010, 1100), state enum {ST_HEAD, ST_WRITE}.
- Sub-module pxie_pulse_stretch (restartable PULSE_LEN counter), instantiated three times for O_Rst, O_Trig, O_run.

## Test plan
- Reset, then EB9C_0003_0000_0064 and EB9C_0004_0000_0002 → O_Trig_Num=0x64, O_Trig_Step=2 next cycle; EB9C..0002 → O_Trig high exactly 50 cycles.
- EB01_0003_0000_0100 then EB9C_0000_0000_1001 then 3 payloads with one VLD gap → O_wr_en=4'b0010 at addrs 0x100,0x102,0x104; header immediately after last payload decoded.
- Opcode 1000+7 with NUM_CH=4 → O_err=1, no write, state ST_HEAD; EB9C..0001 → O_err cleared, O_Rst 50 cycles.
- Burst len 5, send 2 words then idle TIMEOUT_CYC cycles → O_err=1, ST_HEAD, exactly 2 strobes (macro defined); undefined → still busy.
- Second trig command 20 cycles into a pulse → O_Trig continuous for 70 cycles total.
- I_Rst_n low mid-burst → all outputs 0 next edge, subsequent header decoded normally.

Source files
------------

// File: rtl/pxie_rx_pkg.sv
// pxie_rx_pkg: header tags, sub-field codes, opcodes and FSM state type shared by the PXIe command decoder
package pxie_rx_pkg;
  localparam logic [15:0] TAG_CMD   = 16'hEB9C;
  localparam logic [15:0] TAG_BASE  = 16'hEB00;
  localparam logic [15:0] TAG_C2H   = 16'hEBF0;
  localparam logic [15:0] SUB_CMD   = 16'h0000;
  localparam logic [15:0] SUB_TNUM  = 16'h0003;
  localparam logic [15:0] SUB_TSTEP = 16'h0004;
  localparam logic [15:0] OP_RST    = 16'h0001;
  localparam logic [15:0] OP_TRIG   = 16'h0002;
  localparam logic [15:0] OP_BURST  = 16'h1000;
  localparam logic [15:0] OP_C2H    = 16'h1010;
  localparam logic [15:0] OP_RUN    = 16'h1100;
  typedef enum logic {ST_HEAD, ST_WRITE} state_t;
endpackage

// File: rtl/pxie_pulse_stretch.sv
// pxie_pulse_stretch: restartable PULSE_LEN-cycle pulse; ports clk_i, rst_ni (sync active-low), start_i, pulse_o (registered)
module pxie_pulse_stretch #(
  parameter int PULSE_LEN = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic pulse_o
);
  localparam int CW = $clog2(PULSE_LEN + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pulse_o <= 1'b0;
    end else if (start_i) begin
      cnt_q   <= CW'(PULSE_LEN - 1);
      pulse_o <= 1'b1;
    end else begin
      pulse_o <= cnt_q != '0;
      cnt_q   <= cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    end
  end
endmodule

// File: rtl/pxie_cmd_decoder.sv
// pxie_cmd_decoder: PXIe host-command decoder (PXIE_RX_TIMEOUT_EN adds burst timeout); in: I_PXIE_CLK, I_Rst_n, I_PXIE_DATA/_VLD; out: pulses, trig cfg, RAM write ports, C2H cfg, O_busy, O_err
module pxie_cmd_decoder
  import pxie_rx_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STEP   = 2,
  parameter int PULSE_LEN   = 50,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              I_PXIE_CLK,
  input  logic              I_Rst_n,
  input  logic [DATA_W-1:0] I_PXIE_DATA,
  input  logic              I_PXIE_DATA_VLD,
  output logic              O_Rst,
  output logic              O_Trig,
  output logic              O_run,
  output logic [31:0]       O_Trig_Num,
  output logic [31:0]       O_Trig_Step,
  output logic [NUM_CH-1:0] O_wr_en,
  output logic [ADDR_W-1:0] O_wr_addr,
  output logic [DATA_W-1:0] O_wr_data,
  output logic [15:0]       O_c2h_addr,
  output logic [15:0]       O_c2h_len,
  output logic              O_c2h_en,
  output logic              O_busy,
  output logic              O_err
);
  state_t            state_q;
  logic [ADDR_W-1:0] base_q [NUM_CH];
  logic [15:0]       len_q  [NUM_CH];
  logic [3:0]        ch_q;
  logic [15:0]       rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       tag, sub, op;
  logic              head, is_cmd, rst_cmd, trig_cmd, run_cmd, c2h_cmd, burst_cmd;
  logic              tnum_cmd, tstep_cmd, c2h_cfg, base_cmd, bad_ch, burst_go, tmo_hit;
  logic [3:0]        cidx;
  logic [ADDR_W-1:0] sel_base;
  logic [15:0]       sel_len;
  always_comb begin
    tag       = I_PXIE_DATA[63:48];
    sub       = I_PXIE_DATA[47:32];
    op        = I_PXIE_DATA[15:0];
    head      = I_PXIE_DATA_VLD && state_q == ST_HEAD;
    is_cmd    = head && tag == TAG_CMD && sub == SUB_CMD;
    rst_cmd   = is_cmd && op == OP_RST;
    trig_cmd  = is_cmd && op == OP_TRIG;
    run_cmd   = is_cmd && op == OP_RUN;
    c2h_cmd   = is_cmd && op == OP_C2H;
    burst_cmd = is_cmd && op[15:4] == OP_BURST[15:4];
    tnum_cmd  = head && tag == TAG_CMD && sub == SUB_TNUM;
    tstep_cmd = head && tag == TAG_CMD && sub == SUB_TSTEP;
    c2h_cfg   = head && tag == TAG_C2H;
    base_cmd  = head && tag[15:4] == TAG_BASE[15:4];
    cidx      = base_cmd ? tag[3:0] : op[3:0];
    bad_ch    = (burst_cmd || base_cmd) && int'(cidx) >= NUM_CH;
    sel_base  = '0;
    sel_len   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_base = cidx == 4'(i) ? base_q[i] : sel_base;
      sel_len  = cidx == 4'(i) ? len_q[i]  : sel_len;
    end
    burst_go  = burst_cmd && !bad_ch && sel_len != '0;
  end
`ifdef PXIE_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  assign tmo_hit = state_q == ST_WRITE && !I_PXIE_DATA_VLD && tmo_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge I_PXIE_CLK) begin
    if (!I_Rst_n || state_q != ST_WRITE || I_PXIE_DATA_VLD || tmo_hit) tmo_q <= '0;
    else tmo_q <= tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif
  assign O_busy = state_q == ST_WRITE;
  always_ff @(posedge I_PXIE_CLK) begin
    if (!I_Rst_n) begin
      state_q     <= ST_HEAD;
      ch_q        <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
      O_Trig_Num  <= '0;
      O_Trig_Step <= '0;
      O_wr_en     <= '0;
      O_wr_addr   <= '0;
      O_wr_data   <= '0;
      O_c2h_addr  <= '0;
      O_c2h_len   <= '0;
      O_c2h_en    <= 1'b0;
      O_err       <= 1'b0;
    end else begin
      O_wr_en  <= '0;
      O_c2h_en <= c2h_cmd;
      O_err    <= rst_cmd ? 1'b0 : (O_err | bad_ch | tmo_hit);
      if (tnum_cmd) O_Trig_Num <= I_PXIE_DATA[31:0];
      if (tstep_cmd) O_Trig_Step <= I_PXIE_DATA[31:0];
      if (c2h_cfg) begin
        O_c2h_addr <= I_PXIE_DATA[15:0];
        O_c2h_len  <= I_PXIE_DATA[31:16];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (base_cmd && !bad_ch && cidx == 4'(i)) begin
          base_q[i] <= ADDR_W'(I_PXIE_DATA[31:0]);
          len_q[i]  <= I_PXIE_DATA[47:32];
        end
      end
      if (state_q == ST_HEAD) begin
        if (burst_go) begin
          state_q <= ST_WRITE;
          ch_q    <= cidx;
          rem_q   <= sel_len;
          addr_q  <= sel_base;
        end
      end else if (I_PXIE_DATA_VLD) begin
        for (int i = 0; i < NUM_CH; i++) O_wr_en[i] <= ch_q == 4'(i);
        O_wr_addr <= addr_q;
        O_wr_data <= I_PXIE_DATA;
        addr_q    <= addr_q + ADDR_W'(ADDR_STEP);
        rem_q     <= rem_q - 16'd1;
        if (rem_q == 16'd1) state_q <= ST_HEAD;
      end else if (tmo_hit) begin
        state_q <= ST_HEAD;
      end
    end
  end
  pxie_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_rst (
    .clk_i(I_PXIE_CLK), .rst_ni(I_Rst_n), .start_i(rst_cmd), .pulse_o(O_Rst)
  );
  pxie_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_trig (
    .clk_i(I_PXIE_CLK), .rst_ni(I_Rst_n), .start_i(trig_cmd), .pulse_o(O_Trig)
  );
  pxie_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_run (
    .clk_i(I_PXIE_CLK), .rst_ni(I_Rst_n), .start_i(run_cmd), .pulse_o(O_run)
  );
endmodule

// File: tb/tb_pxie_cmd_decoder.sv
// tb_pxie_cmd_decoder: self-checking bench for pxie_cmd_decoder (vector table, directed corner sequences, random vs reference model)
module tb_pxie_cmd_decoder;
  localparam int NC = 4;
  localparam int PL = 50;
  localparam int TO = 1024;
  localparam int STEP = 2;
  logic         clk = 1'b0, rstn = 1'b0, vld = 1'b0;
  logic [127:0] din = '0;
  logic         o_rst, o_trig, o_run, o_c2h_en, o_busy, o_err;
  logic [31:0]  o_tnum, o_tstep, o_wr_addr;
  logic [NC-1:0] o_wr_en;
  logic [127:0] o_wr_data;
  logic [15:0]  o_c2a, o_c2l;
  int n_cmp = 0, n_bad = 0;
  pxie_cmd_decoder dut (
    .I_PXIE_CLK(clk), .I_Rst_n(rstn), .I_PXIE_DATA(din), .I_PXIE_DATA_VLD(vld),
    .O_Rst(o_rst), .O_Trig(o_trig), .O_run(o_run), .O_Trig_Num(o_tnum), .O_Trig_Step(o_tstep),
    .O_wr_en(o_wr_en), .O_wr_addr(o_wr_addr), .O_wr_data(o_wr_data), .O_c2h_addr(o_c2a),
    .O_c2h_len(o_c2l), .O_c2h_en(o_c2h_en), .O_busy(o_busy), .O_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic [127:0] d, input logic v);
    din = d;
    vld = v;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    step('0, 1'b0);
    rstn = 1'b1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " rst"}, o_rst, 0);
    chk({nm, " trig"}, o_trig, 0);
    chk({nm, " run"}, o_run, 0);
    chk({nm, " tnum"}, o_tnum, 0);
    chk({nm, " tstep"}, o_tstep, 0);
    chk({nm, " wr_en"}, o_wr_en, 0);
    chk({nm, " wr_addr"}, o_wr_addr, 0);
    chk({nm, " wr_data"}, o_wr_data, 0);
    chk({nm, " c2h"}, {o_c2a, o_c2l, o_c2h_en}, 0);
    chk({nm, " busy"}, o_busy, 0);
    chk({nm, " err"}, o_err, 0);
  endtask
  // reference model: decoder behaviour restated from the command rules
  int          cyc, last_rst, last_trig, last_run, b_ch, b_k, b_len, idle;
  bit          m_busy;
  logic [31:0] m_base [16];
  int          m_len  [16];
  logic [31:0] e_tnum, e_tstep, e_wr_addr;
  logic [15:0] e_c2a, e_c2l;
  logic        e_c2en, e_err;
  logic [NC-1:0] e_wr_en;
  logic [127:0] e_wr_data;
  task automatic mdl_reset();
    last_rst = -1000; last_trig = -1000; last_run = -1000;
    m_busy = 0; b_ch = 0; b_k = 0; b_len = 0; idle = 0;
    for (int i = 0; i < 16; i++) begin m_base[i] = 0; m_len[i] = 0; end
    e_tnum = 0; e_tstep = 0; e_c2a = 0; e_c2l = 0; e_c2en = 0; e_err = 0;
    e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0;
  endtask
  task automatic mdl_step(input logic [127:0] d, input logic v);
    int c;
    cyc++;
    e_c2en = 0;
    e_wr_en = 0;
    if (m_busy) begin
      if (v) begin
        e_wr_en = NC'(1 << b_ch);
        e_wr_addr = m_base[b_ch] + 32'(b_k * STEP);
        e_wr_data = d;
        b_k++;
        idle = 0;
        if (b_k == b_len) m_busy = 0;
      end else begin
`ifdef PXIE_RX_TIMEOUT_EN
        idle++;
        if (idle == TO) begin m_busy = 0; e_err = 1; idle = 0; end
`endif
      end
    end else if (v) begin
      if (d[63:48] == 16'hEB9C && d[47:32] == 16'h0000) begin
        if (d[15:0] == 16'h0001) begin last_rst = cyc; e_err = 0; end
        else if (d[15:0] == 16'h0002) last_trig = cyc;
        else if (d[15:0] == 16'h1100) last_run = cyc;
        else if (d[15:0] == 16'h1010) e_c2en = 1;
        else if (d[15:0] >= 16'h1000 && d[15:0] <= 16'h100F) begin
          c = int'(d[15:0]) - 'h1000;
          if (c >= NC) e_err = 1;
          else if (m_len[c] != 0) begin m_busy = 1; b_ch = c; b_k = 0; b_len = m_len[c]; idle = 0; end
        end
      end else if (d[63:48] == 16'hEB9C && d[47:32] == 16'h0003) e_tnum = d[31:0];
      else if (d[63:48] == 16'hEB9C && d[47:32] == 16'h0004) e_tstep = d[31:0];
      else if (d[63:48] >= 16'hEB00 && d[63:48] <= 16'hEB0F) begin
        c = int'(d[63:48]) - 'hEB00;
        if (c >= NC) e_err = 1;
        else begin m_base[c] = d[31:0]; m_len[c] = int'(d[47:32]); end
      end else if (d[63:48] == 16'hEBF0) begin e_c2a = d[15:0]; e_c2l = d[31:16]; end
    end
  endtask
  task automatic chk_all();
    chk("m_rst", o_rst, (cyc - last_rst) < PL);
    chk("m_trig", o_trig, (cyc - last_trig) < PL);
    chk("m_run", o_run, (cyc - last_run) < PL);
    chk("m_tnum", o_tnum, e_tnum);
    chk("m_tstep", o_tstep, e_tstep);
    chk("m_c2h", {o_c2a, o_c2l, o_c2h_en}, {e_c2a, e_c2l, e_c2en});
    chk("m_wr_en", o_wr_en, e_wr_en);
    chk("m_busy", o_busy, m_busy);
    chk("m_err", o_err, e_err);
    if (e_wr_en != 0) begin
      chk("m_wr_addr", o_wr_addr, e_wr_addr);
      chk("m_wr_data", o_wr_data, e_wr_data);
    end
  endtask
  function automatic logic [127:0] gen_word();
    logic [127:0] w;
    logic [15:0]  op;
    int k, s;
    w = {$urandom, $urandom, $urandom, $urandom};
    k = $urandom_range(0, 9);
    s = $urandom_range(0, 5);
    op = s == 0 ? 16'h0001 : s == 1 ? 16'h0002 : s == 2 ? 16'h1100 : s == 3 ? 16'h1010 :
         16'h1000 + 16'($urandom_range(0, 5));
    if (k == 0) w[63:0] = {16'hEB9C, 16'h0000, 16'($urandom), op};
    else if (k == 1) w[63:32] = {16'hEB9C, 16'h0003};
    else if (k == 2) w[63:32] = {16'hEB9C, 16'h0004};
    else if (k == 3) w[63:0] = {16'hEB00 + 16'($urandom_range(0, 5)), 16'($urandom_range(0, 6)),
                                $urandom_range(0, 1) == 1 ? $urandom : 32'hFFFF_FFFC};
    else if (k == 4) w[63:48] = 16'hEBF0;
    else if (k == 5) w[63:48] = 16'hEB9C;
    return w;
  endfunction
  typedef struct {
    logic [63:0] d;
    logic        v;
    logic [31:0] tnum, tstep;
    logic [15:0] c2a, c2l;
    logic        busy, err;
  } vec_t;
  vec_t tbl [11];
  int n;
  initial begin
    tbl[0]  = '{64'hEB9C_0003_0000_0064, 1'b1, 32'h64, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[1]  = '{64'hEB9C_0004_0000_0002, 1'b1, 32'h64, 32'h2, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[2]  = '{64'hEB9C_0004_0000_0099, 1'b0, 32'h64, 32'h2, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[3]  = '{64'hEBF0_0000_0123_0456, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    tbl[4]  = '{64'h1234_0003_0000_0777, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    tbl[5]  = '{64'hEB9C_0000_0000_1007, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b1};
    tbl[6]  = '{64'hEB9C_0000_0000_0001, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    tbl[7]  = '{64'hEB05_0001_0000_0000, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b1};
    tbl[8]  = '{64'hEB9C_0000_0000_0001, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    tbl[9]  = '{64'hEB9C_0000_0000_1000, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    tbl[10] = '{64'hEB9C_0001_0000_0003, 1'b1, 32'h64, 32'h2, 16'h0456, 16'h0123, 1'b0, 1'b0};
    step('0, 1'b0);
    rstn = 1'b1;
    chk_zero("reset");
    for (int i = 0; i < 11; i++) begin
      step({64'h0, tbl[i].d}, tbl[i].v);
      chk($sformatf("tbl%0d tnum", i), o_tnum, tbl[i].tnum);
      chk($sformatf("tbl%0d tstep", i), o_tstep, tbl[i].tstep);
      chk($sformatf("tbl%0d c2h", i), {o_c2a, o_c2l}, {tbl[i].c2a, tbl[i].c2l});
      chk($sformatf("tbl%0d busy", i), o_busy, tbl[i].busy);
      chk($sformatf("tbl%0d err", i), o_err, tbl[i].err);
      chk($sformatf("tbl%0d wr_en", i), o_wr_en, 0);
    end
    do_reset();
    step({64'h0, 64'hEB9C_0000_0000_0002}, 1'b1);
    n = o_trig;
    repeat (60) begin step('0, 1'b0); n += o_trig; end
    chk("trig_len", n, PL);
    step({64'h0, 64'hEB9C_0000_0000_0002}, 1'b1);
    n = o_trig;
    repeat (19) begin step('0, 1'b0); n += o_trig; end
    step({64'h0, 64'hEB9C_0000_0000_0002}, 1'b1);
    n += o_trig;
    repeat (80) begin step('0, 1'b0); n += o_trig; end
    chk("trig_restart_len", n, 70);
    do_reset();
    step({64'h0, 64'hEB01_0003_0000_0100}, 1'b1);
    step({64'h0, 64'hEB9C_0000_0000_1001}, 1'b1);
    chk("burst busy", o_busy, 1);
    step(128'hA0, 1'b1);
    chk("p0 en", o_wr_en, 4'b0010);
    chk("p0 addr", o_wr_addr, 32'h100);
    chk("p0 data", o_wr_data, 128'hA0);
    step('0, 1'b0);
    chk("gap en", o_wr_en, 0);
    step(128'hA1, 1'b1);
    chk("p1 en", o_wr_en, 4'b0010);
    chk("p1 addr", o_wr_addr, 32'h102);
    step(128'hA2, 1'b1);
    chk("p2 en", o_wr_en, 4'b0010);
    chk("p2 addr", o_wr_addr, 32'h104);
    chk("p2 data", o_wr_data, 128'hA2);
    chk("p2 busy", o_busy, 0);
    step({64'h0, 64'hEB9C_0003_0000_0055}, 1'b1);
    chk("post tnum", o_tnum, 32'h55);
    chk("post en", o_wr_en, 0);
    do_reset();
    step({64'h0, 64'hEB9C_0000_0000_1007}, 1'b1);
    chk("bad err", o_err, 1);
    chk("bad busy", o_busy, 0);
    chk("bad en", o_wr_en, 0);
    step({64'h0, 64'hEB9C_0000_0000_0001}, 1'b1);
    chk("clr err", o_err, 0);
    n = o_rst;
    repeat (60) begin step('0, 1'b0); n += o_rst; end
    chk("rst_len", n, PL);
    do_reset();
    step({64'h0, 64'hEB02_0005_0000_0200}, 1'b1);
    step({64'h0, 64'hEB9C_0000_0000_1002}, 1'b1);
    n = 0;
    step(128'hB0, 1'b1); n += int'(o_wr_en != 0);
    step(128'hB1, 1'b1); n += int'(o_wr_en != 0);
    chk("tmo addr", o_wr_addr, 32'h202);
    repeat (TO - 1) begin step('0, 1'b0); n += int'(o_wr_en != 0); end
    chk("tmo busy early", o_busy, 1);
    chk("tmo err early", o_err, 0);
    step('0, 1'b0);
    n += int'(o_wr_en != 0);
`ifdef PXIE_RX_TIMEOUT_EN
    chk("tmo busy", o_busy, 0);
    chk("tmo err", o_err, 1);
`else
    chk("notmo busy", o_busy, 1);
    chk("notmo err", o_err, 0);
`endif
    chk("tmo strobes", n, 2);
    do_reset();
    step({64'h0, 64'hEB9C_0003_0000_0011}, 1'b1);
    step({64'h0, 64'hEB9C_0000_0000_0002}, 1'b1);
    step({64'h0, 64'hEB03_0005_0000_0300}, 1'b1);
    step({64'h0, 64'hEB9C_0000_0000_1003}, 1'b1);
    step(128'hC0, 1'b1);
    chk("mid en", o_wr_en, 4'b1000);
    chk("mid addr", o_wr_addr, 32'h300);
    rstn = 1'b0;
    step(128'hC1, 1'b1);
    rstn = 1'b1;
    chk_zero("midrst");
    step({64'h0, 64'hEB9C_0003_0000_0042}, 1'b1);
    chk("after rst tnum", o_tnum, 32'h42);
    step({64'h0, 64'hEB9C_0000_0000_1003}, 1'b1);
    chk("after rst len0", o_busy, 0);
    do_reset();
    cyc = 0;
    mdl_reset();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rstn = 1'b0;
        step(gen_word(), 1'b1);
        rstn = 1'b1;
        cyc++;
        mdl_reset();
      end else begin
        logic [127:0] w;
        logic         v;
        w = gen_word();
        v = $urandom_range(0, 3) != 0;
        step(w, v);
        mdl_step(w, v);
      end
      chk_all();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
